// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns a symbolic request into a 32-bit machine word
// and hands it out through a 2-entry FIFO with an auto-incrementing word address.
module instr_encoder #(
  parameter int              ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              err
);

  localparam logic [3:0] K_ADDU = 4'd0;
  localparam logic [3:0] K_SUBU = 4'd1;
  localparam logic [3:0] K_ORI  = 4'd2;
  localparam logic [3:0] K_LW   = 4'd3;
  localparam logic [3:0] K_SW   = 4'd4;
  localparam logic [3:0] K_BEQ  = 4'd5;
  localparam logic [3:0] K_LUI  = 4'd6;
  localparam logic [3:0] K_JAL  = 4'd7;
  localparam logic [3:0] K_JR   = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [31:0]       mem_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              err_reg;
  logic              accept;
  logic              push;
  logic              pop;

  // Each kind selects only its own fields so unused inputs never reach the word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_kind)
      K_ADDU:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h0, 6'h21};
      K_SUBU:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h0, 6'h23};
      K_ORI:   enc_word = {6'h0D, in_rs, in_rt, in_imm};
      K_LW:    enc_word = {6'h23, in_rs, in_rt, in_imm};
      K_SW:    enc_word = {6'h2B, in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {6'h04, in_rs, in_rt, in_imm};
      K_LUI:   enc_word = {6'h0F, 5'h0, in_rt, in_imm};
      K_JAL:   enc_word = {6'h03, in_target};
      K_JR:    enc_word = {6'h00, in_rs, 15'h0, 6'h08};
      K_J:     enc_word = {6'h02, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // No bypass: a full FIFO refuses even when the head leaves this cycle.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_word  = mem_reg[rd_ptr_reg];
  assign out_addr  = addr_reg;
  assign err       = err_reg;

  assign accept = in_valid & in_ready;
  assign push   = accept & enc_legal;
  assign pop    = out_valid & out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem_reg[gi] <= 32'h0;
        else if (push && (wr_ptr_reg == 1'(gi)))
          mem_reg[gi] <= enc_word;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      addr_reg   <= BASE;
      err_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        addr_reg   <= addr_reg + 1'b1;
      end
      if (accept && !enc_legal)
        err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected words checked
// against the write port, plus a narrow-address instance for counter wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_word;
  logic        err;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [25:0] w_in_target = '0;
  logic        w_out_valid;
  logic [1:0]  w_out_addr;
  logic [31:0] w_out_word;
  logic        w_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [9:0]  exp_addr = '0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE(10'd0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_word(out_word), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .BASE(2'd2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_kind(4'd9),
    .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0), .in_imm(16'd0), .in_target(w_in_target),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_addr(w_out_addr),
    .out_word(w_out_word), .err(w_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that
  // follows the accepting rising edge.
  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic [31:0] exp, input bit legal);
    bit done = 0;
    in_valid = 1'b1; in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        if (legal) exp_q.push_back(exp);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    $display("send kind=%0d word=%h legal=%0d", kind, exp, legal);
  endtask

  // Scoreboard side: every word leaving on the write port is checked in order.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          check("word", out_word, exp_q[0]);
          check("addr", 32'(out_addr), 32'(exp_addr));
          $display("pop addr=%0d word=%h", out_addr, out_word);
          void'(exp_q.pop_front());
          exp_addr = exp_addr + 10'd1;
        end
      end
    end
  end

  initial begin
    automatic int wexp[5] = '{2, 3, 0, 1, 2};
    automatic logic [31:0] head_word;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", out_word, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_addr", 32'(out_addr), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("wrap_rst_addr", 32'(w_out_addr), 32'd2);

    // Golden words; unused fields carry junk that must not leak into the word.
    out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF, 32'h00221821, 1);
    check("latency", 32'(out_valid), 32'd1);
    send(4'd2, 5'd0, 5'd8, 5'd31, 16'h1234, 26'h2AAAAAA, 32'h34081234, 1);
    send(4'd3, 5'd29, 5'd9, 5'd7, 16'h0004, 26'h1555555, 32'h8FA90004, 1);
    send(4'd6, 5'd7, 5'd1, 5'd7, 16'hABCD, 26'h3FFFFFF, 32'h3C01ABCD, 1);
    send(4'd5, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h1022FFFF, 1);
    send(4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C00, 32'h0C000C00, 1);
    send(4'd8, 5'd31, 5'd5, 5'd9, 16'hFFFF, 26'h3FFFFFF, 32'h03E00008, 1);
    send(4'd4, 5'd2, 5'd3, 5'd0, 16'h8000, 26'h0, 32'hAC438000, 1);
    send(4'd9, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1234567, 32'h09234567, 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset with two words queued.
    out_ready = 1'b0;
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h11, 32'h08000011, 1);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h22, 32'h08000022, 1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_addr", 32'(out_addr), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    exp_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal kind between two subu requests.
    out_ready = 1'b1;
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h3FFFFFF, 32'h00853023, 1);
    check("err_before", 32'(err), 32'd0);
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0, 0);
    check("err_after", 32'(err), 32'd1);
    send(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 32'h00E84823, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("illegal_addr", 32'(out_addr), 32'd2);

    // Backpressure: third request must stall while head stays put.
    out_ready = 1'b0;
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h101, 32'h08000101, 1);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h102, 32'h08000102, 1);
    in_valid = 1'b1; in_kind = 4'd9; in_target = 26'h103;
    head_word = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_head_word", out_word, head_word);
      check("bp_head_addr", 32'(out_addr), 32'(exp_addr));
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h103, 32'h08000103, 1);
    repeat (4) @(negedge clk);

    // Streaming at occupancy 1: push and pop every cycle.
    send(4'd2, 5'd1, 5'd2, 5'd0, 16'h0000, 26'h0, 32'h34220000, 1);
    for (int i = 1; i <= 8; i++) begin
      send(4'd2, 5'd1, 5'd2, 5'd0, 16'(i), 26'h0, 32'h34220000 | 32'(i), 1);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready), 32'd1);
    end

    // Address wrap on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      w_in_valid = 1'b1; w_in_target = 26'(i + 5);
      @(negedge clk);
      check("wrap_valid", 32'(w_out_valid), 32'd1);
      check("wrap_word", w_out_word, {6'h02, 26'(i + 5)});
      check("wrap_addr", 32'(w_out_addr), 32'(wexp[i]));
      $display("wrap addr=%0d word=%h", w_out_addr, w_out_word);
    end
    w_in_valid = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
